// File: rtl/agu_pkg.sv
// Shared widths and the address-buffer payload type for the AGU pipeline.
package agu_pkg;

    localparam int unsigned AGU_DATA_W = 16;
    localparam int unsigned TAG_W      = 5;
    localparam int unsigned PA_W       = 5;
    localparam int unsigned IMM_W      = 5;

    // One buffered effective address together with the ROB tag it belongs to.
    typedef struct packed {
        logic [AGU_DATA_W-1:0] addr;
        logic [TAG_W-1:0]      tag_ROB;
    } agu_entry_t;

endpackage

// File: rtl/agu_fifo.sv
// In-order address buffer between the AGU stage register and the load/store unit.
module agu_fifo
    import agu_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     flush,
    input  logic                     push,
    input  agu_entry_t               push_data,
    input  logic                     pop,
    output agu_entry_t               head,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = PW + 1;

    agu_entry_t       mem [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic             do_pop;

    // A pop request against an empty buffer is ignored.
    assign do_pop = pop && (count != '0);

    // Head entry is presented only while the buffer holds something.
    assign head = (count != '0) ? mem[rd_ptr] : '0;

    // Storage, pointers and occupancy; reset clears everything, flush only empties.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= wr_ptr + PW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            case ({push, do_pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    // The upstream stall must make a push into a full buffer impossible.
    no_overflow: assert property (@(posedge clk) disable iff (rst || flush)
        !(push && (count == CW'(DEPTH)) && !do_pop));

endmodule

// File: rtl/agu_pipe.sv
// Address generation: base register + immediate, one stage register, then an in-order buffer.
module agu_pipe
    import agu_pkg::*;
#(
    parameter int unsigned DATA_W = AGU_DATA_W,
    parameter int unsigned DEPTH  = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              valid_op_awake,
    input  logic [PA_W-1:0]   Pa_awake,
    input  logic [IMM_W-1:0]  Imm_awake,
    input  logic [TAG_W-1:0]  tag_ROB_awake,
    output logic              freeze_back,
    output logic [PA_W-1:0]   rd_addr,
    input  logic [DATA_W-1:0] rd_data,
    output logic              valid_addr,
    output logic [DATA_W-1:0] addr_out,
    output logic [TAG_W-1:0]  tag_ROB_out,
    input  logic              ready_ls
);

    localparam int unsigned CW = $clog2(DEPTH) + 1;
    localparam int unsigned OW = CW + 1;

    logic [DATA_W-1:0] ea;
    logic              s1_valid;
    agu_entry_t        s1_entry;
    agu_entry_t        head;
    logic [CW-1:0]     count;
    logic [OW-1:0]     occupancy;
    logic              pop;

    // The register file is read combinationally with the issued base tag.
    assign rd_addr = Pa_awake;

    // Effective address wraps modulo 2^DATA_W; the carry out is dropped.
    assign ea = rd_data + DATA_W'(Imm_awake);

    // Stage register S1; flush and reset squash an op captured in the same cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid <= 1'b0;
            s1_entry <= '0;
        end else if (flush) begin
            s1_valid <= 1'b0;
        end else begin
            s1_valid <= valid_op_awake;
            if (valid_op_awake) begin
                s1_entry.addr    <= AGU_DATA_W'(ea);
                s1_entry.tag_ROB <= tag_ROB_awake;
            end
        end
    end

    // S1 always drains into the buffer; the stall below guarantees room.
    agu_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .push      (s1_valid),
        .push_data (s1_entry),
        .pop       (pop),
        .head      (head),
        .count     (count)
    );

    // Output side and stall: the stall counts S1 and the op on the wire because the
    // reservation station sees it a cycle late; a same-cycle pop is deliberately ignored.
    always_comb begin
        valid_addr  = (count != '0) && !flush;
        pop         = valid_addr && ready_ls;
        addr_out    = DATA_W'(head.addr);
        tag_ROB_out = head.tag_ROB;
        occupancy   = OW'(count) + OW'(s1_valid) + OW'(valid_op_awake);
        freeze_back = occupancy >= OW'(DEPTH);
    end

endmodule

// File: tb/tb_agu_pipe.sv
// Self-checking bench for agu_pipe: vector table, corner-case sequences, scoreboarded stream.
module tb_agu_pipe;

    logic        clk;
    logic        rst;
    logic        flush;
    logic        valid_op_awake;
    logic [4:0]  Pa_awake;
    logic [4:0]  Imm_awake;
    logic [4:0]  tag_ROB_awake;
    logic        freeze_back;
    logic [4:0]  rd_addr;
    logic [15:0] rd_data;
    logic        valid_addr;
    logic [15:0] addr_out;
    logic [4:0]  tag_ROB_out;
    logic        ready_ls;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [15:0] addr;
        logic [4:0]  tag;
    } exp_t;

    typedef struct {
        logic [15:0] rd;
        logic [4:0]  imm;
        logic [4:0]  tag;
        logic [15:0] addr;
    } vec_t;

    exp_t sbq[$];
    exp_t drv_exp;
    vec_t vecs[6];

    agu_pipe #(
        .DATA_W (16),
        .DEPTH  (4)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .flush          (flush),
        .valid_op_awake (valid_op_awake),
        .Pa_awake       (Pa_awake),
        .Imm_awake      (Imm_awake),
        .tag_ROB_awake  (tag_ROB_awake),
        .freeze_back    (freeze_back),
        .rd_addr        (rd_addr),
        .rd_data        (rd_data),
        .valid_addr     (valid_addr),
        .addr_out       (addr_out),
        .tag_ROB_out    (tag_ROB_out),
        .ready_ls       (ready_ls)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: simulation still running, required to finish");
        $fatal(1, "timeout");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [15:0] ea_model(input logic [15:0] rd, input logic [4:0] imm);
        logic [16:0] sum;
        sum = {1'b0, rd} + {12'd0, imm};
        return sum[15:0];
    endfunction

    task automatic issue(input logic [15:0] rd, input logic [4:0] imm, input logic [4:0] tag,
                         input logic [15:0] exp_addr);
        valid_op_awake = 1'b1;
        rd_data        = rd;
        Imm_awake      = imm;
        tag_ROB_awake  = tag;
        Pa_awake       = 5'($urandom_range(0, 31));
        drv_exp.addr   = exp_addr;
        drv_exp.tag    = tag;
    endtask

    task automatic idle();
        valid_op_awake = 1'b0;
        rd_data        = 16'($urandom);
        Imm_awake      = 5'($urandom_range(0, 31));
        tag_ROB_awake  = 5'($urandom_range(0, 31));
    endtask

    // Called at the negedge: scoreboard bookkeeping for this cycle, then advance past the posedge.
    task automatic step();
        exp_t e;
        if (valid_addr === 1'b1 && ready_ls) begin
            if (sbq.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL sb_spurious: got addr 0x%0h tag %0d required no output",
                         addr_out, tag_ROB_out);
            end else begin
                e = sbq.pop_front();
                chk("sb_addr", 32'(addr_out), 32'(e.addr));
                chk("sb_tag", 32'(tag_ROB_out), 32'(e.tag));
            end
        end
        if (rst || flush) sbq.delete();
        else if (valid_op_awake) sbq.push_back(drv_exp);
        @(posedge clk);
        #1;
    endtask

    task automatic cyc();
        @(negedge clk);
        step();
    endtask

    task automatic drain();
        int n;
        idle();
        ready_ls = 1'b1;
        n = 0;
        while (sbq.size() != 0 && n < 40) begin
            cyc();
            n++;
        end
        chk("drain_left", 32'(sbq.size()), 32'd0);
        @(negedge clk);
        chk("drain_valid", 32'(valid_addr), 32'd0);
        step();
    endtask

    task automatic fill4(input logic [4:0] base_tag);
        ready_ls = 1'b0;
        for (int k = 0; k < 4; k++) begin
            issue(16'h4000 + 16'(k * 256), 5'(k + 1), base_tag + 5'(k),
                  ea_model(16'h4000 + 16'(k * 256), 5'(k + 1)));
            cyc();
        end
    endtask

    initial begin
        logic prev_freeze;
        logic [15:0] r;
        logic [4:0] im;
        logic [4:0] tg;

        vecs[0] = '{16'h1000, 5'd5,  5'd3,  16'h1005};
        vecs[1] = '{16'hFFFE, 5'd4,  5'd7,  16'h0002};
        vecs[2] = '{16'h0000, 5'd0,  5'd1,  16'h0000};
        vecs[3] = '{16'hFFFF, 5'd31, 5'd30, 16'h001E};
        vecs[4] = '{16'h7FF0, 5'd31, 5'd31, 16'h800F};
        vecs[5] = '{16'h1234, 5'd17, 5'd9,  16'h1245};

        rst = 1'b1; flush = 1'b0; ready_ls = 1'b0;
        valid_op_awake = 1'b0; Pa_awake = '0; Imm_awake = '0; tag_ROB_awake = '0; rd_data = '0;
        drv_exp = '{16'h0, 5'h0};
        cyc();
        cyc();
        rst = 1'b0;

        // Reset state
        @(negedge clk);
        chk("rst_valid", 32'(valid_addr), 32'd0);
        chk("rst_addr", 32'(addr_out), 32'd0);
        chk("rst_tag", 32'(tag_ROB_out), 32'd0);
        chk("rst_freeze", 32'(freeze_back), 32'd0);
        step();

        // Table: single op into an empty buffer, output exactly two cycles later
        ready_ls = 1'b1;
        for (int i = 0; i < 6; i++) begin
            issue(vecs[i].rd, vecs[i].imm, vecs[i].tag, vecs[i].addr);
            @(negedge clk);
            chk("rd_addr", 32'(rd_addr), 32'(Pa_awake));
            chk("lat_n0_valid", 32'(valid_addr), 32'd0);
            step();
            idle();
            @(negedge clk);
            chk("lat_n1_valid", 32'(valid_addr), 32'd0);
            step();
            @(negedge clk);
            chk("lat_n2_valid", 32'(valid_addr), 32'd1);
            chk("lat_n2_addr", 32'(addr_out), 32'(vecs[i].addr));
            chk("lat_n2_tag", 32'(tag_ROB_out), 32'(vecs[i].tag));
            step();
            @(negedge clk);
            chk("lat_n3_valid", 32'(valid_addr), 32'd0);
            step();
        end

        // Fill with consumer stalled: stall rises when count+s1+op reaches 4
        ready_ls = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            issue(16'h2000 + 16'(k * 16), 5'(k), 5'(k), ea_model(16'h2000 + 16'(k * 16), 5'(k)));
            @(negedge clk);
            chk("fill_freeze", 32'(freeze_back), (k == 4) ? 32'd1 : 32'd0);
            step();
        end
        idle();
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            chk("full_freeze", 32'(freeze_back), 32'd1);
            chk("full_valid", 32'(valid_addr), 32'd1);
            chk("full_head_tag", 32'(tag_ROB_out), 32'd1);
            step();
        end
        drain();

        // Simultaneous push and pop at count 2
        ready_ls = 1'b0;
        issue(16'h0100, 5'd1, 5'd10, 16'h0101); cyc();
        issue(16'h0200, 5'd2, 5'd11, 16'h0202); cyc();
        issue(16'h0300, 5'd3, 5'd12, 16'h0303); cyc();
        idle();
        ready_ls = 1'b1;
        @(negedge clk);
        chk("pp_head_before", 32'(tag_ROB_out), 32'd10);
        chk("pp_freeze_before", 32'(freeze_back), 32'd0);
        step();
        ready_ls = 1'b0;
        issue(16'h0400, 5'd4, 5'd13, 16'h0404);
        @(negedge clk);
        chk("pp_head_after", 32'(tag_ROB_out), 32'd11);
        chk("pp_valid_after", 32'(valid_addr), 32'd1);
        chk("pp_freeze_cnt2", 32'(freeze_back), 32'd0);
        step();
        issue(16'h0500, 5'd5, 5'd14, 16'h0505);
        @(negedge clk);
        chk("pp_freeze_cnt2_s1", 32'(freeze_back), 32'd1);
        step();
        drain();

        // Flush with three buffered, one in S1 and one on the wire
        fill4(5'd20);
        issue(16'h5000, 5'd9, 5'd25, 16'h5009);
        flush = 1'b1;
        @(negedge clk);
        chk("flush_cycle_valid", 32'(valid_addr), 32'd0);
        step();
        flush = 1'b0;
        idle();
        @(negedge clk);
        chk("post_flush_valid", 32'(valid_addr), 32'd0);
        chk("post_flush_freeze", 32'(freeze_back), 32'd0);
        chk("post_flush_addr", 32'(addr_out), 32'd0);
        step();
        ready_ls = 1'b1;
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            chk("post_flush_quiet", 32'(valid_addr), 32'd0);
            step();
        end

        // Reset together with flush while the buffer is full
        fill4(5'd16);
        idle();
        cyc();
        cyc();
        rst = 1'b1;
        flush = 1'b1;
        ready_ls = 1'b1;
        issue(16'h6000, 5'd1, 5'd2, 16'h6001);
        cyc();
        rst = 1'b0;
        flush = 1'b0;
        idle();
        @(negedge clk);
        chk("rstf_valid", 32'(valid_addr), 32'd0);
        chk("rstf_addr", 32'(addr_out), 32'd0);
        chk("rstf_tag", 32'(tag_ROB_out), 32'd0);
        chk("rstf_freeze", 32'(freeze_back), 32'd0);
        step();
        issue(16'hABC0, 5'd15, 5'd6, 16'hABCF);
        cyc();
        idle();
        @(negedge clk);
        chk("rstf_n1_valid", 32'(valid_addr), 32'd0);
        step();
        @(negedge clk);
        chk("rstf_n2_valid", 32'(valid_addr), 32'd1);
        chk("rstf_n2_addr", 32'(addr_out), 32'hABCF);
        chk("rstf_n2_tag", 32'(tag_ROB_out), 32'd6);
        step();
        drain();

        // Random stream; the issuer obeys the stall one cycle late
        prev_freeze = 1'b0;
        for (int i = 0; i < 80; i++) begin
            ready_ls = 1'($urandom_range(0, 1));
            if (!prev_freeze && $urandom_range(0, 3) != 0) begin
                r  = 16'($urandom);
                im = 5'($urandom_range(0, 31));
                tg = 5'(i);
                issue(r, im, tg, ea_model(r, im));
            end else begin
                idle();
            end
            @(negedge clk);
            prev_freeze = freeze_back;
            step();
        end
        drain();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
